maj_chain_serial: RTL and testbench

Parametrised, sequential successor to the flat majority-gate carry chain. The block evaluates the ripple recurrence c[i+1] = MAJ(c[i], a[i], b'[i]) over WIDTH stages, BITS_PER_CYCLE stages per clock, LSB first. It returns the final carry, the full carry vector, and an XNOR-tapped result bit. It sits behind a valid/ready request port and in front of a valid/ready result port in the datapath compare/accumulate logic.

---
 rtl/maj_chain_serial_if.sv | 29 ++
 rtl/maj_chain_serial.sv | 129 ++++++++++++
 tb/tb_maj_chain_serial.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/maj_chain_serial_if.sv
// Request/result handshake bundle for maj_chain_serial.
// The master drives requests and accepts results; the slave is the chain block.
interface maj_chain_serial_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             tap;
  logic             mode;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             carry;
  logic [WIDTH-1:0] carry_vec;
  logic             result;

  modport master (
    output in_valid, a, b, cin, tap, mode, flush, out_ready,
    input  in_ready, out_valid, carry, carry_vec, result
  );

  modport slave (
    input  in_valid, a, b, cin, tap, mode, flush, out_ready,
    output in_ready, out_valid, carry, carry_vec, result
  );
endinterface

// File: rtl/maj_chain_serial.sv
// Serial majority-gate carry chain: BITS_PER_CYCLE ripple stages per clock,
// LSB first, behind valid/ready request and result ports.
module maj_chain_serial #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic               clk,
  input logic               rst_n,
  maj_chain_serial_if.slave bus
);
  localparam int STEPS  = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int BASE_W = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] cvec_q, cvec_d;
  logic             c_q, c_d;
  logic             tap_q, tap_d;
  logic             carry_q, carry_d;
  logic             result_q, result_d;

  logic [BASE_W-1:0]         base;
  logic [BITS_PER_CYCLE-1:0] a_slice;
  logic [BITS_PER_CYCLE-1:0] b_slice;
  logic [BITS_PER_CYCLE:0]   chain;

  assign base    = BASE_W'(cnt_q) * BASE_W'(BITS_PER_CYCLE);
  assign a_slice = a_q[base +: BITS_PER_CYCLE];
  assign b_slice = b_q[base +: BITS_PER_CYCLE];

  // Evaluated in one procedural pass so the ripple through this cycle's stages
  // is an ordered chain rather than a self-referencing vector.
  always_comb begin
    chain    = '0;
    chain[0] = c_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      chain[i+1] = (chain[i] & a_slice[i]) | (chain[i] & b_slice[i]) |
                   (a_slice[i] & b_slice[i]);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    cvec_d   = cvec_q;
    c_d      = c_q;
    tap_d    = tap_q;
    carry_d  = carry_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = bus.a;
          b_d     = bus.mode ? ~bus.b : bus.b;
          c_d     = bus.mode ? 1'b1 : bus.cin;
          tap_d   = bus.tap;
          cvec_d  = '0;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
          carry_d = 1'b0;
          cvec_d  = '0;
        end else begin
          cvec_d[base +: BITS_PER_CYCLE] = chain[BITS_PER_CYCLE:1];
          c_d   = chain[BITS_PER_CYCLE];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(STEPS - 1)) begin
            state_d  = DONE;
            carry_d  = chain[BITS_PER_CYCLE];
            result_d = ~(tap_q ^ chain[BITS_PER_CYCLE]);
          end
        end
      end
      DONE: begin
        if (bus.flush) begin
          state_d = IDLE;
          carry_d = 1'b0;
          cvec_d  = '0;
        end else if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cvec_q   <= '0;
      c_q      <= 1'b0;
      tap_q    <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cvec_q   <= cvec_d;
      c_q      <= c_d;
      tap_q    <= tap_d;
      carry_q  <= carry_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.carry     = carry_q;
  assign bus.carry_vec = cvec_q;
  assign bus.result    = result_q;
endmodule

// File: tb/tb_maj_chain_serial.sv
// Bench: two chains (1 and 4 stages per clock) driven with identical requests
// and checked against an arithmetic model of the carry recurrence.
module tb_maj_chain_serial;
  localparam int W  = 8;
  localparam int W1 = W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid, flush, out_ready, cin, tap, mode;
  logic [W-1:0] a, b;

  maj_chain_serial_if #(.WIDTH(W)) if1 ();
  maj_chain_serial_if #(.WIDTH(W)) if4 ();

  assign if1.in_valid  = in_valid;
  assign if1.a         = a;
  assign if1.b         = b;
  assign if1.cin       = cin;
  assign if1.tap       = tap;
  assign if1.mode      = mode;
  assign if1.flush     = flush;
  assign if1.out_ready = out_ready;
  assign if4.in_valid  = in_valid;
  assign if4.a         = a;
  assign if4.b         = b;
  assign if4.cin       = cin;
  assign if4.tap       = tap;
  assign if4.mode      = mode;
  assign if4.flush     = flush;
  assign if4.out_ready = out_ready;

  maj_chain_serial #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  maj_chain_serial #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  logic         ov[2], ir[2], cy[2], rs[2];
  logic [W-1:0] cv[2];
  assign ov[0] = if1.out_valid;
  assign ov[1] = if4.out_valid;
  assign ir[0] = if1.in_ready;
  assign ir[1] = if4.in_ready;
  assign cy[0] = if1.carry;
  assign cy[1] = if4.carry;
  assign rs[0] = if1.result;
  assign rs[1] = if4.result;
  assign cv[0] = if1.carry_vec;
  assign cv[1] = if4.carry_vec;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   bpc[2]   = '{1, 4};
  logic prev_carry[2];
  logic prev_result[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: carry into bit i+1 is bit i+1 of the sum of the low i+1 bits.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                       input logic ttap, input logic tmode,
                       output logic [W-1:0] ecv, output logic ecy, output logic ers);
    logic [W-1:0] bp;
    logic         c0;
    logic [W:0]   m, s;
    bp  = tmode ? ~tb : tb;
    c0  = tmode ? 1'b1 : tcin;
    ecv = '0;
    for (int i = 0; i < W; i++) begin
      m      = W1'((32'd1 << (i + 1)) - 32'd1);
      s      = ({1'b0, ta} & m) + ({1'b0, bp} & m) + {{W{1'b0}}, c0};
      ecv[i] = s[i+1];
    end
    s   = {1'b0, ta} + {1'b0, bp} + {{W{1'b0}}, c0};
    ecy = tmode ? (ta >= tb) : s[W];
    ers = ~(ttap ^ ecy);
  endtask

  task automatic chk_idle_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s d%0d out_valid", tag, d), 32'(ov[d]), 32'(1'b0));
      chk($sformatf("%s d%0d in_ready", tag, d), 32'(ir[d]), 32'(1'b1));
      chk($sformatf("%s d%0d carry", tag, d), 32'(cy[d]), 32'(1'b0));
      chk($sformatf("%s d%0d carry_vec", tag, d), 32'(cv[d]), 32'(8'h00));
      chk($sformatf("%s d%0d result", tag, d), 32'(rs[d]), 32'(prev_result[d]));
    end
  endtask

  // Called just after a negedge; accepts on the next posedge, then holds the
  // result port back for 'hold' cycles past the slower chain's completion.
  task automatic do_txn(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                        input logic ttap, input logic tmode, input int hold);
    logic [W-1:0] ecv, m;
    logic         ecy, ers, done;
    int           n;
    model(ta, tb, tcin, ttap, tmode, ecv, ecy, ers);
    a = ta; b = tb; cin = tcin; tap = ttap; mode = tmode;
    in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int d = 0; d < 2; d++)
      chk($sformatf("a=%0h b=%0h d%0d in_ready after accept", ta, tb, d), 32'(ir[d]), 32'(1'b0));
    for (int k = 1; k <= W + hold; k++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      tap = 1'($urandom); mode = 1'($urandom); in_valid = 1'($urandom);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        done = (k >= W / bpc[d]);
        n    = done ? W : k * bpc[d];
        m    = W'((32'd1 << n) - 32'd1);
        chk($sformatf("a=%0h b=%0h m=%0d k%0d d%0d out_valid", ta, tb, tmode, k, d), 32'(ov[d]), 32'(done));
        chk($sformatf("a=%0h b=%0h m=%0d k%0d d%0d carry_vec", ta, tb, tmode, k, d), 32'(cv[d]), 32'(ecv & m));
        chk($sformatf("a=%0h b=%0h m=%0d k%0d d%0d carry", ta, tb, tmode, k, d), 32'(cy[d]),
            32'(done ? ecy : prev_carry[d]));
        chk($sformatf("a=%0h b=%0h m=%0d k%0d d%0d result", ta, tb, tmode, k, d), 32'(rs[d]),
            32'(done ? ers : prev_result[d]));
        chk($sformatf("a=%0h b=%0h k%0d d%0d in_ready", ta, tb, k, d), 32'(ir[d]), 32'(1'b0));
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("a=%0h b=%0h d%0d out_valid after take", ta, tb, d), 32'(ov[d]), 32'(1'b0));
      chk($sformatf("a=%0h b=%0h d%0d in_ready after take", ta, tb, d), 32'(ir[d]), 32'(1'b1));
      chk($sformatf("a=%0h b=%0h d%0d carry after take", ta, tb, d), 32'(cy[d]), 32'(ecy));
      prev_carry[d]  = ecy;
      prev_result[d] = ers;
    end
    $display("txn a=%02h b=%02h cin=%0d tap=%0d mode=%0d -> carry=%0d carry_vec=%02h result=%0d",
             ta, tb, tcin, ttap, tmode, ecy, ecv, ers);
  endtask

  initial begin
    logic [W-1:0] ecv;
    logic         ecy, ers;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    cin = 1'b0; tap = 1'b0; mode = 1'b0; a = '0; b = '0;
    for (int d = 0; d < 2; d++) begin
      prev_carry[d]  = 1'b0;
      prev_result[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk_idle_zero("in reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_zero("after reset");

    do_txn(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 2);
    do_txn(8'h05, 8'h05, 1'b0, 1'b1, 1'b1, 0);
    do_txn(8'h04, 8'h05, 1'b1, 1'b1, 1'b1, 0);
    do_txn(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 0);
    do_txn(8'hA5, 8'h5A, 1'b1, 1'b1, 1'b0, 5);

    // Asynchronous reset partway through the run (slow chain mid-RUN, fast chain in DONE).
    a = 8'h3C; b = 8'hC7; cin = 1'b1; tap = 1'b0; mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      prev_carry[d]  = 1'b0;
      prev_result[d] = 1'b0;
    end
    chk_idle_zero("async reset");
    #3 rst_n = 1'b1;
    @(negedge clk);
    $display("txn async reset mid-run -> outputs cleared");
    do_txn(8'h80, 8'h80, 1'b0, 1'b1, 1'b0, 0);

    // Flush at RUN step 2 with a competing request in the same cycle.
    model(8'h6E, 8'h2B, 1'b1, 1'b1, 1'b0, ecv, ecy, ers);
    a = 8'h6E; b = 8'h2B; cin = 1'b1; tap = 1'b1; mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h91; b = 8'h91; cin = 1'b0; tap = 1'b0; mode = 1'b1;
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    prev_result[1] = ers;
    prev_carry[0]  = 1'b0;
    prev_carry[1]  = 1'b0;
    chk_idle_zero("flush");
    $display("txn flush at step 2 -> idle, carry_vec cleared");
    do_txn(8'h91, 8'h91, 1'b0, 1'b0, 1'b1, 0);

    for (int t = 0; t < 24; t++)
      do_txn(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
